// File: rtl/float12_pkg.sv
// Shared definitions for the 12-bit float datapath: 1 sign, 5 exponent (bias 15), 6 fraction.
package float12_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 6;
    localparam int BIAS  = 15;

    localparam logic [11:0] F12_ZERO    = 12'h000;
    localparam logic [10:0] F12_MAX_MAG = 11'h7FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_OUT
    } state_e;

endpackage

// File: rtl/float12_round.sv
// Round-half-up of a packed {exp, man} magnitude; the all-ones magnitude saturates instead of wrapping.
module float12_round #(
    parameter int W = 11
) (
    input  logic [W-1:0] val_i,
    input  logic         guard_i,
    output logic [W-1:0] val_o
);

    assign val_o = (val_i == {W{1'b1}}) ? val_i : val_i + {{(W-1){1'b0}}, guard_i};

endmodule

// File: rtl/div_12.sv
// Iterative 12-bit float divider (restoring, one quotient bit per cycle, valid/ready both sides).
// Define DIV12_EARLY_OUT_EN to skip the iteration when either operand is zero.
module div_12 #(
    parameter int EXP_W = float12_pkg::EXP_W,
    parameter int MAN_W = float12_pkg::MAN_W,
    parameter int BIAS  = float12_pkg::BIAS
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [EXP_W+MAN_W:0]   data_1_i,
    input  logic [EXP_W+MAN_W:0]   data_2_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EXP_W+MAN_W:0]   data_div_o
);
    import float12_pkg::*;

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int EW    = EXP_W + 2;
    localparam int QW    = MAN_W + 3;
    localparam int CW    = $clog2(QW + 1);

    localparam logic [W-2:0]          MAX_MAG  = {(W-1){1'b1}};
    localparam logic signed [EW-1:0]  EXP_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0]  EXP_TOP  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]  EXP_ONE  = EW'(1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(QW - 1);

    state_e                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [SIG_W:0]         rem_q, rem_d;
    logic [SIG_W-1:0]       dvs_q, dvs_d;
    logic [QW-1:0]          quo_q, quo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   zero_a_q, zero_a_d;
    logic                   zero_b_q, zero_b_d;
    logic [W-1:0]           res_q, res_d;

    logic                   sgn_a, sgn_b, in_zero_a, in_zero_b;
    logic [EXP_W-1:0]       exp_a, exp_b;
    logic [MAN_W-1:0]       man_a, man_b;
    logic signed [EW-1:0]   exp_in;

    assign sgn_a     = data_1_i[W-1];
    assign sgn_b     = data_2_i[W-1];
    assign exp_a     = data_1_i[W-2:MAN_W];
    assign exp_b     = data_2_i[W-2:MAN_W];
    assign man_a     = data_1_i[MAN_W-1:0];
    assign man_b     = data_2_i[MAN_W-1:0];
    assign in_zero_a = (data_1_i[W-2:0] == '0);
    assign in_zero_b = (data_2_i[W-2:0] == '0);
    assign exp_in    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + EXP_BIAS;

    // Restoring step: remainder stays below the divisor after subtraction, so the shift cannot overflow.
    logic             div_ge;
    logic [SIG_W:0]   rem_sub, rem_next;

    assign div_ge   = (rem_q >= {1'b0, dvs_q});
    assign rem_sub  = div_ge ? (rem_q - {1'b0, dvs_q}) : rem_q;
    assign rem_next = {rem_sub[SIG_W-1:0], 1'b0};

    // Quotient lies in (0.5, 2): the top bit selects which window holds the fraction.
    logic signed [EW-1:0]   exp_n;
    logic [MAN_W-1:0]       man_n;
    logic                   guard_n, exp_over;
    logic [W-2:0]           rounded;
    logic [W-1:0]           norm_res;

    assign exp_n    = quo_q[QW-1] ? exp_q : (exp_q - EXP_ONE);
    assign man_n    = quo_q[QW-1] ? quo_q[QW-2:2] : quo_q[QW-3:1];
    assign guard_n  = quo_q[QW-1] ? quo_q[1] : quo_q[0];
    assign exp_over = (exp_n > EXP_TOP);

    float12_round #(
        .W (W - 1)
    ) u_round (
        .val_i   ({exp_n[EXP_W-1:0], man_n}),
        .guard_i (guard_n),
        .val_o   (rounded)
    );

    always_comb begin
        norm_res = {sign_q, rounded};
        if (zero_a_q || (exp_n[EW-1] && !zero_b_q)) begin
            norm_res = '0;
        end else if (zero_b_q || exp_over) begin
            norm_res = {sign_q, MAX_MAG};
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        zero_a_d = zero_a_q;
        zero_b_d = zero_b_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    sign_d   = sgn_a ^ sgn_b;
                    exp_d    = exp_in;
                    rem_d    = {1'b0, 1'b1, man_a};
                    dvs_d    = {1'b1, man_b};
                    quo_d    = '0;
                    cnt_d    = '0;
                    zero_a_d = in_zero_a;
                    zero_b_d = in_zero_b;
                    state_d  = S_DIV;
`ifdef DIV12_EARLY_OUT_EN
                    if (in_zero_a || in_zero_b) begin
                        res_d   = in_zero_a ? '0 : {sgn_a ^ sgn_b, MAX_MAG};
                        state_d = S_OUT;
                    end
`endif
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                quo_d = {quo_q[QW-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                res_d   = norm_res;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            zero_a_q <= 1'b0;
            zero_b_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            zero_a_q <= zero_a_d;
            zero_b_q <= zero_b_d;
            res_q    <= res_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_OUT);
    assign data_div_o  = res_q;

endmodule
